// File: rtl/instruction_prefetcher_pkg.sv
// Shared types and constants for the instruction prefetcher: instruction
// field layout, special opcodes/words and the fetch FSM encoding.
package proctypes;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int NUM_INSTRUCTIONS  = 64;

  // iType occupies the low bits of every instruction word.
  localparam int ITYPE_LSB   = 0;
  localparam int ITYPE_WIDTH = 3;

  // A shape-set instruction makes the following word opaque data.
  localparam logic [ITYPE_WIDTH-1:0] OP_SHAPE_SET = 3'd6;

  // Word that sends the fetch pointer back to the restart address.
  localparam logic [INSTRUCTION_WIDTH-1:0] LOOP_WORD = {21'b0, 2'b11, 6'b0, 3'b0};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic is_shape_set(input logic [INSTRUCTION_WIDTH-1:0] word);
    return word[ITYPE_LSB +: ITYPE_WIDTH] == OP_SHAPE_SET;
  endfunction

endpackage

// File: rtl/instruction_prefetcher_ram.sv
// Simple dual-port RAM: one write port, one read port with a fixed
// LATENCY-stage registered read pipeline. Contents survive reset.
module xilinx_simple_dual_port_ram #(
  parameter int  WIDTH   = 32,
  parameter int  DEPTH   = 64,
  parameter int  LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] pipe [LATENCY];

  // NOTE: storage arrays carry no reset; validity is tracked by separate
  // reset flags, so resetting the data would only cost logic.
  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: array read followed by the remaining pipeline stages.
  always_ff @(posedge clk) begin
    if (re) pipe[0] <= mem[raddr];
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/instruction_prefetcher.sv
// Instruction prefetcher: streams words from instruction memory into a small
// queue, recognising terminator and loop words, with redirect support.
module instruction_prefetcher
  import proctypes::*;
#(
  parameter int  INST_WIDTH   = INSTRUCTION_WIDTH,
  parameter int  DEPTH        = NUM_INSTRUCTIONS,
  parameter int  FIFO_DEPTH   = 4,
  parameter int  RAM_LATENCY  = 2,
  parameter int  RESTART_ADDR = 1,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [INST_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  start,
  input  logic                  redirect,
  input  logic [AW-1:0]         redirect_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [AW-1:0]         pc_out,
  output logic                  halted
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RAM_LATENCY + 2) + 1;

  fetch_state_t state;
  logic [AW-1:0] pc;

  // Read tags travel alongside the RAM pipeline, then a return stage.
  logic [RAM_LATENCY-1:0] tag_v;
  logic [AW-1:0]          tag_a [RAM_LATENCY];
  logic                   ret_v;
  logic [INST_WIDTH-1:0]  ret_data;
  logic [AW-1:0]          ret_addr;
  logic [INST_WIDTH-1:0]  rd_data;

  // Prefetch queue.
  logic [INST_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
  logic [AW-1:0]         fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;

  // Last pushed word was a shape-set: the next word is taken verbatim.
  logic last_shape;

  logic          pop, push, hit_term, hit_loop, flush, rd_en, ram_we;
  logic [CW-1:0] in_flight, credit_used;

  // Flow decisions: pop/push, special-word detection and read issue credit.
  always_comb begin
    // NOTE: every output of this block gets a value first, so no path
    // can leave one unassigned and infer a latch.
    pop         = (count != '0) && out_ready;
    hit_term    = ret_v && !last_shape && (ret_data == '0);
    hit_loop    = ret_v && !last_shape && (ret_data == INST_WIDTH'(LOOP_WORD));
    flush       = redirect || hit_term || hit_loop;
    push        = ret_v && !flush;
    in_flight   = CW'(ret_v);
    for (int i = 0; i < RAM_LATENCY; i++) in_flight = in_flight + CW'(tag_v[i]);
    // The slot being popped this cycle is free again at the same edge.
    credit_used = CW'(count) - CW'(pop) + in_flight;
    rd_en       = (state == RUN) && !flush && (credit_used < CW'(FIFO_DEPTH));
    ram_we      = wr_en && (state != RUN);
  end

  xilinx_simple_dual_port_ram #(
    .WIDTH  (INST_WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(RAM_LATENCY)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(pc),
    .rdata(rd_data)
  );

  // Address/data path of the read pipeline and the queue storage.
  always_ff @(posedge clk) begin
    tag_a[0] <= pc;
    for (int i = 1; i < RAM_LATENCY; i++) tag_a[i] <= tag_a[i-1];
    ret_data <= rd_data;
    ret_addr <= tag_a[RAM_LATENCY-1];
    if (push) begin
      fifo_inst[wr_ptr] <= ret_data;
      fifo_pc[wr_ptr]   <= ret_addr;
    end
  end

  // Fetch FSM, read-tag valids and queue bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      tag_v      <= '0;
      ret_v      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_shape <= 1'b0;
      halted     <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      // NOTE: with non-blocking assignments the last one in the block wins,
      // so the flush cases below cleanly override the default advance.
      wr_err <= wr_en && (state == RUN);
      tag_v  <= (tag_v << 1) | RAM_LATENCY'(rd_en);
      ret_v  <= tag_v[RAM_LATENCY-1];
      if (rd_en) pc <= pc + AW'(1);
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_shape <= is_shape_set(INSTRUCTION_WIDTH'(ret_data));
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

      if (redirect) begin
        tag_v      <= '0;
        ret_v      <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        pc         <= redirect_addr;
        last_shape <= 1'b0;
        state      <= RUN;
        halted     <= 1'b0;
      end else if (hit_term) begin
        tag_v  <= '0;
        ret_v  <= 1'b0;
        state  <= HALT;
        halted <= 1'b1;
      end else if (hit_loop) begin
        tag_v <= '0;
        ret_v <= 1'b0;
        pc    <= AW'(RESTART_ADDR);
      end else if (start && (state != RUN)) begin
        pc         <= '0;
        last_shape <= 1'b0;
        state      <= RUN;
        halted     <= 1'b0;
      end
    end
  end

  assign out_valid = (count != '0);
  assign inst      = out_valid ? fifo_inst[rd_ptr] : '0;
  assign pc_out    = out_valid ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Self-checking bench for instruction_prefetcher: directed memory images plus
// randomized images and back-pressure, checked against a sequential model.
module tb_instruction_prefetcher;
  import proctypes::*;

  localparam int IW      = 32;
  localparam int DEPTH   = 64;
  localparam int FD      = 4;
  localparam int LAT     = 2;
  localparam int RESTART = 1;
  localparam int AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [IW-1:0] wr_data = '0;
  logic          wr_err;
  logic          start = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc_out;
  logic          halted;

  instruction_prefetcher #(
    .INST_WIDTH  (IW),
    .DEPTH       (DEPTH),
    .FIFO_DEPTH  (FD),
    .RAM_LATENCY (LAT),
    .RESTART_ADDR(RESTART)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .start        (start),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .inst         (inst),
    .pc_out       (pc_out),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [IW-1:0] mem_m [DEPTH];
  int            exp_pc[$];
  logic [IW-1:0] exp_inst[$];
  bit            exp_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write the whole model memory through the loader port.
  task automatic load_all();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = mem_m[a];
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("load_wr_err", wr_err, 0);
  endtask

  // Walk memory word by word applying the terminator/loop/shape-set rules.
  task automatic build_model(input int start_addr, input int n_max);
    int            a;
    bit            prev_ss;
    int            steps;
    logic [IW-1:0] w;
    a = start_addr; prev_ss = 0; steps = 0; exp_halt = 0;
    exp_pc.delete(); exp_inst.delete();
    while (exp_pc.size() < n_max && steps < 100000) begin
      w = mem_m[a];
      steps++;
      if (!prev_ss && w == '0) begin
        exp_halt = 1;
        break;
      end
      if (!prev_ss && w == LOOP_WORD) begin
        a = RESTART;
        continue;
      end
      exp_pc.push_back(a);
      exp_inst.push_back(w);
      prev_ss = (w[ITYPE_LSB +: ITYPE_WIDTH] == OP_SHAPE_SET);
      a = (a + 1) % DEPTH;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Consume the stream after the trigger edge; k counts negedges after it.
  task automatic consume(input int pct, input bit no_bubble, output int delivered);
    int k;
    bit seen;
    k = 0; seen = 0; delivered = 0;
    while (exp_pc.size() != 0) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < pct);
      if (out_valid) begin
        if (!seen) check("first_valid_latency", k, LAT + 2);
        seen = 1;
        check("pc_out", pc_out, exp_pc[0]);
        check("inst", inst, exp_inst[0]);
        if (out_ready) begin
          void'(exp_pc.pop_front());
          void'(exp_inst.pop_front());
          delivered++;
        end
      end else if (seen && no_bubble) begin
        check("bubble", out_valid, 1);
      end
      k++;
      if (k > 400) begin
        check("stream_timeout", exp_pc.size(), 0);
        break;
      end
    end
  endtask

  task automatic tail_halt();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_valid_after_halt", out_valid, 0);
    end
    check("halted", halted, 1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [IW-1:0] rand_word();
    int            r;
    logic [IW-1:0] w;
    r = $urandom_range(99);
    w = $urandom;
    if (r < 8) w = '0;
    else if (r < 13) w = LOOP_WORD;
    else if (r < 30) w[ITYPE_LSB +: ITYPE_WIDTH] = OP_SHAPE_SET;
    else if (w == '0 || w == LOOP_WORD) w = 32'h1;
    return w;
  endfunction

  initial begin
    int got;
    int reads;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_wr_err", wr_err, 0);
    rst = 1'b0;

    // Words 1..8 at 0..7, full-rate stream, halt at address 8.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = (i < 8) ? IW'(i + 1) : '0;
    load_all();
    build_model(0, 1000);
    out_ready = 1'b1;
    pulse_start();
    consume(100, 1, got);
    tail_halt();
    check("seq_delivered", got, 8);

    // Terminator at 3; loaded while halted, restarted from HALT.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h1234;
    for (int i = 0; i < 3; i++) mem_m[i] = 32'h100 + i;
    mem_m[3] = '0;
    load_all();
    build_model(0, 1000);
    pulse_start();
    consume(70, 0, got);
    tail_halt();
    check("term_delivered", got, 3);

    // Shape-set at 2 protects the zero at 3; zero at 4 halts.
    mem_m[0] = 32'h111; mem_m[1] = 32'h222; mem_m[2] = 32'hAB6;
    mem_m[3] = '0;      mem_m[4] = '0;
    load_all();
    build_model(0, 1000);
    pulse_start();
    consume(60, 0, got);
    tail_halt();
    check("shape_delivered", got, 4);

    // Loop word at 5: 0..4 then 1..4 repeatedly.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int i = 0; i < 5; i++) mem_m[i] = 32'h10 + i;
    mem_m[5] = LOOP_WORD;
    load_all();
    build_model(0, 30);
    pulse_start();
    consume(100, 0, got);
    check("loop_delivered", got, 30);
    // Reset mid-stream clears outputs immediately.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pc_out", pc_out, 0);
    check("midrst_inst", inst, 0);
    check("midrst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-pressure, write refused in RUN, redirect concurrent with a pop.
    for (int i = 0; i < DEPTH; i++) mem_m[i] = {16'hA5A5, 8'(i), 8'h01};
    load_all();
    out_ready = 1'b0;
    pulse_start();
    reads = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      reads += int'(dut.rd_en);
      if (k >= 4) begin
        check("stall_valid", out_valid, 1);
        check("stall_pc", pc_out, 0);
        check("stall_inst", inst, mem_m[0]);
      end
    end
    check("stall_reads_le_depth", reads <= FD, 1);
    wr_en = 1'b1; wr_addr = AW'(16); wr_data = ~mem_m[16];
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_err_pulse", wr_err, 1);
    @(negedge clk);
    check("wr_err_once", wr_err, 0);
    out_ready = 1'b1; redirect = 1'b1; redirect_addr = AW'(16);
    check("redir_pop_valid", out_valid, 1);
    check("redir_pop_pc", pc_out, 0);
    @(posedge clk);
    #1 redirect = 1'b0;
    build_model(16, 12);
    consume(100, 1, got);
    check("redir_delivered", got, 12);

    // Memory survives reset.
    reset_pulse();
    build_model(0, 20);
    pulse_start();
    consume(50, 0, got);

    // Randomized images and back-pressure.
    for (int it = 0; it < 6; it++) begin
      reset_pulse();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = rand_word();
      mem_m[RESTART] = $urandom | 32'h100;
      load_all();
      build_model(0, 40);
      pulse_start();
      consume($urandom_range(30, 100), 0, got);
      if (exp_halt) tail_halt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
